// File: rtl/mdu_pkg.sv
// mdu_pkg: shared widths, op codes and FSM states for the HI/LO multiply/divide unit.
package mdu_pkg;
   localparam int DATA_W = 32;
   localparam int HILO_W = 64;
   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_NOP   = 3'd6
   } op_e;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_e;
endpackage

// File: rtl/mdu_div32.sv
// mdu_div32: combinational 32-bit signed/unsigned divide, quotient truncated toward zero.
module mdu_div32
   import mdu_pkg::*;
(
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic              i_signed,
   output logic [DATA_W-1:0] o_q,
   output logic [DATA_W-1:0] o_r,
   output logic              o_dz
);
   logic              w_na, w_nb, w_ovf;
   logic [DATA_W-1:0] w_ua, w_ub, w_ubs, w_uq, w_ur;
   assign o_dz  = i_b == '0;
   assign w_ovf = i_signed && i_a == 32'h8000_0000 && i_b == 32'hFFFF_FFFF;
   assign w_na  = i_signed & i_a[DATA_W-1];
   assign w_nb  = i_signed & i_b[DATA_W-1];
   assign w_ua  = w_na ? -i_a : i_a;
   assign w_ub  = w_nb ? -i_b : i_b;
   // keep the divider defined on B=0; the caller discards this result
   assign w_ubs = o_dz ? DATA_W'(1) : w_ub;
   assign w_uq  = w_ua / w_ubs;
   assign w_ur  = w_ua % w_ubs;
   assign o_q   = w_ovf ? 32'h8000_0000 : (w_na ^ w_nb) ? -w_uq : w_uq;
   assign o_r   = w_ovf ? '0 : w_na ? -w_ur : w_ur;
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle MULT/DIV unit owning the architectural HI/LO pair.
module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Start,
   input  logic [2:0]        Op,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic              Cancel,
   output logic              Busy,
   output logic              Done,
   output logic [DATA_W-1:0] Hi,
   output logic [DATA_W-1:0] Lo,
   output logic [HILO_W-1:0] HiLoData
);
   localparam int MAX_C = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W = $clog2(MAX_C) + 1;
   state_e            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [HILO_W-1:0] r_pend;
   logic [DATA_W-1:0] r_hi, r_lo;
   logic              r_done;
   logic              w_go, w_mul, w_div, w_dz;
   logic [DATA_W-1:0] w_q, w_r;
   logic [HILO_W-1:0] w_prod, w_div_res;
   assign w_go  = Start && !Cancel && r_state == ST_IDLE;
   assign w_mul = Op == OP_MULT || Op == OP_MULTU;
   assign w_div = Op == OP_DIV || Op == OP_DIVU;
   // the low 64 bits of a 64x64 product of extended operands give the exact result
   assign w_prod = Op == OP_MULT ? {{DATA_W{A[DATA_W-1]}}, A} * {{DATA_W{B[DATA_W-1]}}, B}
                                 : {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};
   mdu_div32 u_div (
      .i_a(A),
      .i_b(B),
      .i_signed(Op == OP_DIV),
      .o_q(w_q),
      .o_r(w_r),
      .o_dz(w_dz)
   );
   assign w_div_res = w_dz ? {r_hi, r_lo} : {w_r, w_q};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_pend  <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == ST_IDLE) begin
            if (w_go && w_mul) begin
               r_pend  <= w_prod;
               r_cnt   <= CNT_W'(MULT_CYCLES - 1);
               r_state <= ST_MUL;
            end else if (w_go && w_div) begin
               r_pend  <= w_div_res;
               r_cnt   <= CNT_W'(DIV_CYCLES - 1);
               r_state <= ST_DIV;
            end
            if (w_go && Op == OP_MTHI) r_hi <= A;
            if (w_go && Op == OP_MTLO) r_lo <= A;
         end else if (Cancel) begin
            r_state <= ST_IDLE;
         end else if (r_cnt == '0) begin
            {r_hi, r_lo} <= r_pend;
            r_done       <= 1'b1;
            r_state      <= ST_IDLE;
         end else begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end
   assign Busy     = r_state != ST_IDLE;
   assign Done     = r_done;
   assign Hi       = r_hi;
   assign Lo       = r_lo;
   assign HiLoData = {r_hi, r_lo};
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: vector table, hand-written corner sequences and random ops against an arithmetic model.
module tb_mdu_hilo;
   localparam int MC = 5;
   localparam int DC = 10;
   logic        clk, rst, Start, Cancel, Busy, Done;
   logic [2:0]  Op;
   logic [31:0] A, B, Hi, Lo;
   logic [63:0] HiLoData, m_hilo;
   int          checks, failures;

   mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .rst(rst), .Start(Start), .Op(Op), .A(A), .B(B), .Cancel(Cancel),
      .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .HiLoData(HiLoData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b, hi, lo;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic int lat_of(input logic [2:0] op);
      return op < 3'd2 ? MC : op < 3'd4 ? DC : 0;
   endfunction

   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [63:0] cur);
      longint sa, sb, q, r;
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         3'd0: return sa * sb;
         3'd1: return {32'b0, a} * {32'b0, b};
         3'd2: begin
            if (b == 0) return cur;
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'd3: return b == 0 ? cur : {a % b, a / b};
         3'd4: return {a, cur[31:0]};
         3'd5: return {cur[63:32], a};
         default: return cur;
      endcase
   endfunction

   // Issues one op at the current negedge and returns at the negedge of the Done cycle (or T0+1).
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
      int n, lat;
      lat = lat_of(op);
      Start = 1'b1; Op = op; A = a; B = b;
      @(negedge clk);
      Start = 1'b0;
      chk("done_low_after_issue", {63'b0, Done}, 64'd0);
      n = 0;
      while (Busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("busy_cycles", 64'(n), 64'(lat));
      chk("done_pulse", {63'b0, Done}, {63'b0, lat > 0});
      chk("hilodata", HiLoData, exp);
      chk("hi_lo", {Hi, Lo}, exp);
   endtask

   vec_t vecs[10];

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; Start = 1'b0; Cancel = 1'b0; Op = 3'd6; A = '0; B = '0;
      vecs[0] = '{3'd4, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0};
      vecs[1] = '{3'd5, 32'h9ABC_DEF0, 32'h0,         32'h1234_5678, 32'h9ABC_DEF0};
      vecs[2] = '{3'd0, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
      vecs[3] = '{3'd1, 32'hFFFF_FFFE, 32'h3,         32'h0000_0002, 32'hFFFF_FFFA};
      vecs[4] = '{3'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[5] = '{3'd3, 32'h7,         32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[6] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
      vecs[7] = '{3'd3, 32'h7,         32'h2,         32'h1,         32'h3};
      vecs[8] = '{3'd7, 32'h55,        32'h66,        32'h1,         32'h3};
      vecs[9] = '{3'd2, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD};
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", {63'b0, Busy}, 64'd0);
      chk("rst_done", {63'b0, Done}, 64'd0);
      chk("rst_hilo", HiLoData, 64'd0);

      foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});

      // MTHI while busy must be ignored
      Start = 1'b1; Op = 3'd0; A = 32'd4; B = 32'd4;
      @(negedge clk);
      Start = 1'b1; Op = 3'd4; A = 32'hDEAD_BEEF;
      @(negedge clk);
      Start = 1'b0;
      chk("busy_mthi_hi", {32'b0, Hi}, 64'h1);
      for (int n = 0; n < 20 && Busy; n++) @(negedge clk);
      chk("busy_mthi_done", {63'b0, Done}, 64'd1);
      chk("busy_mthi_res", HiLoData, 64'd16);

      // Cancel together with Start in IDLE drops the op
      Start = 1'b1; Cancel = 1'b1; Op = 3'd4; A = 32'h55;
      @(negedge clk);
      Start = 1'b0; Cancel = 1'b0;
      chk("cancel_idle_mthi", HiLoData, 64'd16);
      chk("cancel_idle_busy", {63'b0, Busy}, 64'd0);

      run_op(3'd4, 32'hAAAA, 32'h0, {32'hAAAA, 32'd16});
      run_op(3'd5, 32'h77, 32'h0, {32'hAAAA, 32'h77});

      // Cancel in the 3rd busy cycle of MULT 4x4
      Start = 1'b1; Op = 3'd0; A = 32'd4; B = 32'd4;
      @(negedge clk);
      Start = 1'b0;
      repeat (2) @(negedge clk);
      chk("cancel_busy_before", {63'b0, Busy}, 64'd1);
      Cancel = 1'b1;
      @(negedge clk);
      Cancel = 1'b0;
      chk("cancel_busy_after", {63'b0, Busy}, 64'd0);
      chk("cancel_hilo_kept", HiLoData, {32'hAAAA, 32'h77});
      for (int n = 0; n < 8; n++) begin
         chk("cancel_no_done", {63'b0, Done}, 64'd0);
         @(negedge clk);
      end
      run_op(3'd0, 32'd4, 32'd4, 64'd16);

      // Cancel on the completion edge wins
      Start = 1'b1; Op = 3'd0; A = 32'd4; B = 32'd5;
      @(negedge clk);
      Start = 1'b0;
      repeat (MC - 1) @(negedge clk);
      Cancel = 1'b1;
      @(negedge clk);
      Cancel = 1'b0;
      chk("cancel_last_busy", {63'b0, Busy}, 64'd0);
      chk("cancel_last_done", {63'b0, Done}, 64'd0);
      chk("cancel_last_hilo", HiLoData, 64'd16);

      m_hilo = 64'd16;
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom_range(0, 5) == 0 ? 32'h0 : $urandom;
         if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         m_hilo = model(op, a, b, m_hilo);
         run_op(op, a, b, m_hilo);
      end

      // Asynchronous reset in the middle of a DIV
      Start = 1'b1; Op = 3'd2; A = 32'd100; B = 32'd7;
      @(negedge clk);
      Start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_rst_busy", {63'b0, Busy}, 64'd0);
      chk("async_rst_hilo", {Hi, Lo}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         chk("rst_no_done", {63'b0, Done}, 64'd0);
      end
      chk("rst_hilo_after", HiLoData, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
